mc_maindec: RTL and testbench

- Multicycle main control FSM, directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and muxes, plus the 2-bit aluop that the ALU decoder combines with funct to form alucontrol.
- Adds a mem_ready wait handshake so the shared instruction/data memory may take multiple cycles.

---
 rtl/mc_pkg.sv | 78 +++++++
 rtl/mc_maindec_outdec.sv | 83 ++++++++
 rtl/mc_maindec.sv | 111 +++++++++++
 tb/tb_mc_maindec.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle main decoder and the ALU decoder.
// Optional build macro: MC_MAINDEC_BNE_EN (adds the bne instruction path).
package mc_pkg;

    // Opcodes recognised by the main decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // aluop encodings shared with the ALU decoder; 2'b11 is never produced
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    // PC source selects (2'b00 = ALU result is the idle value)
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states; encodings 13..15 are unreachable
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    // Datapath control bundle produced by the output decoder
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
    } ctrl_t;

    // State that follows DECODE for a given opcode; FETCH means unsupported
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return MEMADR;
            OP_RTYPE:     return RTYPEEX;
            OP_BEQ:       return BEQEX;
            OP_ADDI:      return ADDIEX;
            OP_J:         return JEX;
`ifdef MC_MAINDEC_BNE_EN
            OP_BNE:       return BNEEX;
`else
            OP_BNE:       return FETCH;
`endif
            default:      return FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_maindec_outdec.sv
// mc_maindec_outdec: pure state-to-control decode for the multicycle controller.
// Optional build macro: MC_MAINDEC_BNE_EN (adds the bne output for BNEEX).
module mc_maindec_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
`ifdef MC_MAINDEC_BNE_EN
    output logic       bne,
`endif
    output ctrl_t      ctrl
);

    // Moore decode; only FETCH looks at mem_ready so the PC/IR update once per fetch
    always_comb begin
        ctrl = '0;
`ifdef MC_MAINDEC_BNE_EN
        bne  = 1'b0;
`endif
        case (state)
            FETCH: begin
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
`ifdef MC_MAINDEC_BNE_EN
            BNEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                bne          = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main control FSM with a mem_ready wait handshake.
// Optional build macro: MC_MAINDEC_BNE_EN (adds BNEEX state and bne port).
module mc_maindec
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
`ifdef MC_MAINDEC_BNE_EN
    output logic       bne,
`endif
    output logic       illegal_op
);

    logic [STATE_W-1:0] state_q;
    logic [3:0]         cur;
    state_t             nxt;
    ctrl_t              ctrl;
    ctrl_t              ctrl_g;
    logic               illegal_raw;
`ifdef MC_MAINDEC_BNE_EN
    logic               bne_raw;
`endif

    // Any nonzero bit above the 4-bit encoding is treated as an unreachable state
    always_comb begin
        cur = state_q[3:0];
        if ((state_q >> 4) != '0)
            cur = 4'hF;
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE:  nxt = decode_target(op);
            MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWB:   nxt = FETCH;
            MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
            RTYPEEX: nxt = RTYPEWB;
            RTYPEWB: nxt = FETCH;
            BEQEX:   nxt = FETCH;
            ADDIEX:  nxt = ADDIWB;
            ADDIWB:  nxt = FETCH;
            JEX:     nxt = FETCH;
            default: nxt = FETCH;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= STATE_W'(FETCH);
        else
            state_q <= STATE_W'(nxt);
    end

    mc_maindec_outdec u_outdec (
        .state     (cur),
        .mem_ready (mem_ready),
`ifdef MC_MAINDEC_BNE_EN
        .bne       (bne_raw),
`endif
        .ctrl      (ctrl)
    );

    // illegal_op flags an unsupported opcode during the single DECODE cycle
    always_comb begin
        illegal_raw = (cur == DECODE) && (decode_target(op) == FETCH);
    end

    // Outputs are cleared while reset is held, without waiting for a clock edge
    always_comb begin
        ctrl_g = reset_n ? ctrl : '0;
    end

    assign aluop      = ctrl_g.aluop;
    assign alusrca    = ctrl_g.alusrca;
    assign alusrcb    = ctrl_g.alusrcb;
    assign pcsrc      = ctrl_g.pcsrc;
    assign iord       = ctrl_g.iord;
    assign memtoreg   = ctrl_g.memtoreg;
    assign regdst     = ctrl_g.regdst;
    assign irwrite    = ctrl_g.irwrite;
    assign pcwrite    = ctrl_g.pcwrite;
    assign branch     = ctrl_g.branch;
    assign regwrite   = ctrl_g.regwrite;
    assign memwrite   = ctrl_g.memwrite;
    assign illegal_op = reset_n & illegal_raw;
`ifdef MC_MAINDEC_BNE_EN
    assign bne        = reset_n & bne_raw;
`endif

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: scoreboard bench for mc_maindec; honours MC_MAINDEC_BNE_EN.
module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] op = 6'd0;
    logic [1:0] aluop, alusrcb, pcsrc;
    logic       alusrca, iord, memtoreg, regdst, irwrite, pcwrite;
    logic       branch, regwrite, memwrite, illegal_op;
`ifdef MC_MAINDEC_BNE_EN
    logic       bne;
`endif

    mc_maindec #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .aluop      (aluop),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
`ifdef MC_MAINDEC_BNE_EN
        .bne        (bne),
`endif
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       memwrite;
        logic       illegal_op;
`ifdef MC_MAINDEC_BNE_EN
        logic       bne;
`endif
    } exp_t;

    typedef struct {
        exp_t  v;
        string name;
    } item_t;

    typedef enum {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_BNE, C_ILL} cls_t;

    exp_t  act;
    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    assign act = {aluop, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
                  irwrite, pcwrite, branch, regwrite, memwrite, illegal_op
`ifdef MC_MAINDEC_BNE_EN
                  , bne
`endif
                  };

    task automatic compare(input string nm, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Monitor: every sampled cycle with a pending expectation is checked
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                compare(it.name, act, it.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] rop();
        return 6'($urandom_range(63, 0));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Instruction classes as the architecture defines them
    function automatic cls_t classify(input logic [5:0] o);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
`ifdef MC_MAINDEC_BNE_EN
            6'b000101: return C_BNE;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    // One clock of stimulus plus the response expected during that clock
    task automatic cycle(input logic [5:0] o, input logic mr, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        op = o;
        mem_ready = mr;
        sb.push_back('{v: e, name: nm});
    endtask

    // Assert reset between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        compare("reset_async", act, '0);
        repeat (2) cycle(rop(), 1'b0, '0, "in_reset");
        @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Reference behaviour: an instruction is a list of architectural steps
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit abort);
        exp_t e;
        cls_t c;
        c = classify(o);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.alusrcb = 2'b01;
            cycle(rop(), 1'b0, e, "fetch_wait");
        end
        e = '0; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1;
        cycle(rop(), 1'b1, e, "fetch");
        e = '0; e.alusrcb = 2'b11; e.illegal_op = (c == C_ILL);
        cycle(o, rbit(), e, "decode");
        case (c)
            C_LW, C_SW: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cycle(o, rbit(), e, "memadr");
                e = '0; e.iord = 1'b1; e.memwrite = (c == C_SW);
                for (int i = 0; i < mw; i++)
                    cycle(rop(), 1'b0, e, (c == C_SW) ? "memwr_wait" : "memrd_wait");
                if (abort) begin
                    @(negedge clk);
                    do_reset();
                    return;
                end
                cycle(rop(), 1'b1, e, (c == C_SW) ? "memwr" : "memrd");
                if (c == C_LW) begin
                    e = '0; e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    cycle(rop(), rbit(), e, "memwb");
                end
            end
            C_R: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
                cycle(rop(), rbit(), e, "rtypeex");
                e = '0; e.regdst = 1'b1; e.regwrite = 1'b1;
                cycle(rop(), rbit(), e, "rtypewb");
            end
            C_BEQ: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1'b1;
                cycle(rop(), rbit(), e, "beqex");
            end
            C_ADDI: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cycle(rop(), rbit(), e, "addiex");
                e = '0; e.regwrite = 1'b1;
                cycle(rop(), rbit(), e, "addiwb");
            end
            C_J: begin
                e = '0; e.pcsrc = 2'b10; e.pcwrite = 1'b1;
                cycle(rop(), rbit(), e, "jex");
            end
`ifdef MC_MAINDEC_BNE_EN
            C_BNE: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.bne = 1'b1;
                cycle(rop(), rbit(), e, "bneex");
            end
`endif
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] pool [8];
        logic [5:0] o;
        pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b001000, 6'b000010, 6'b000101, 6'b111111};

        do_reset();
        run_instr(6'b100011, 0, 0, 1'b0);
        run_instr(6'b000000, 2, 0, 1'b0);
        run_instr(6'b101011, 0, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b000101, 0, 0, 1'b0);
        run_instr(6'b001000, 1, 0, 1'b0);
        run_instr(6'b100011, 0, 1, 1'b1);
        run_instr(6'b000000, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3, 0) == 0)
                o = rop();
            else
                o = pool[$urandom_range(7, 0)];
            run_instr(o, $urandom_range(2, 0), $urandom_range(3, 0), 1'b0);
        end
        run_instr(6'b101011, 1, 2, 1'b1);
        run_instr(6'b000100, 0, 0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
